// File: rtl/neopixel_strip_ctrl_if.sv
// Host/serialiser signal bundle for neopixel_strip_ctrl.
// slave = the sequencer; master = everything around it (host logic plus writepixel).
interface neopixel_strip_ctrl_if #(
    parameter int NUM_PIXELS = 8
);
    localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic [7:0]        bright;
    logic              start;
    logic              busy;
    logic              done;
    logic              px_start;
    logic [7:0]        px_r;
    logic [7:0]        px_g;
    logic [7:0]        px_b;
    logic              px_busy;

    modport master (
        output wr_en, wr_addr, wr_data, bright, start, px_busy,
        input  busy, done, px_start, px_r, px_g, px_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, bright, start, px_busy,
        output busy, done, px_start, px_r, px_g, px_b
    );
endinterface

// File: rtl/neopixel_strip_ctrl.sv
// WS2812 frame sequencer: colour buffer, per-pixel handshake to writepixel, latch gap, done pulse.
// Optional NEOPIXEL_BRIGHTNESS_EN scales each channel by (bright+1)/256 in the FETCH stage.
module neopixel_strip_ctrl #(
    parameter int NUM_PIXELS = 8,
    parameter int CLK_HZ     = 12000000,
    parameter int LATCH_US   = 80
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    neopixel_strip_ctrl_if.slave bus
);
    localparam int ADDR_W       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int LATCH_CYCLES = CLK_HZ / 1000000 * LATCH_US;
    localparam int CNT_W        = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, LATCH
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] index, index_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              busy_q, done_q, pxs_q;
    logic              done_n, pxs_n;
    logic [7:0]        px_r_q, px_g_q, px_b_q;
    logic [7:0]        r_n, g_n, b_n;
    logic [23:0]       rdata;
    logic [23:0]       mem [NUM_PIXELS];

    wire last_px  = (index == ADDR_W'(NUM_PIXELS - 1));
    wire last_cnt = (cnt == CNT_W'(LATCH_CYCLES - 1));

    always_comb begin
        state_n = state;
        index_n = index;
        cnt_n   = cnt;
        done_n  = 1'b0;
        pxs_n   = 1'b0;
        case (state)
            IDLE:      if (bus.start) begin
                           state_n = LOAD;
                           index_n = '0;
                       end
            LOAD:      state_n = FETCH;
            FETCH:     state_n = ISSUE;
            ISSUE:     if (!bus.px_busy) begin
                           pxs_n   = 1'b1;
                           state_n = WAIT_ACK;
                       end
            WAIT_ACK:  if (bus.px_busy) state_n = WAIT_DONE;
            // Compare before incrementing so index never wraps at NUM_PIXELS=2^ADDR_W.
            WAIT_DONE: if (!bus.px_busy) begin
                           if (last_px) begin
                               state_n = LATCH;
                               cnt_n   = '0;
                           end else begin
                               index_n = index + 1'b1;
                               state_n = LOAD;
                           end
                       end
            LATCH:     if (last_cnt) begin
                           state_n = IDLE;
                           done_n  = 1'b1;
                       end else begin
                           cnt_n = cnt + 1'b1;
                       end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            index  <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pxs_q  <= 1'b0;
        end else begin
            state  <= state_n;
            index  <= index_n;
            cnt    <= cnt_n;
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
            pxs_q  <= pxs_n;
        end
    end

    // Buffer is plain RAM: no reset, write-anytime, read issued from LOAD.
    always_ff @(posedge CLK) begin
        if (bus.wr_en && (int'(bus.wr_addr) < NUM_PIXELS))
            mem[bus.wr_addr] <= bus.wr_data;
        if (state == LOAD)
            rdata <= mem[index];
    end

`ifdef NEOPIXEL_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = 17'(c) * 17'({1'b0, b} + 9'd1);
        return p[15:8];
    endfunction

    assign r_n = scale(rdata[23:16], bus.bright);
    assign g_n = scale(rdata[15:8],  bus.bright);
    assign b_n = scale(rdata[7:0],   bus.bright);
`else
    assign r_n = rdata[23:16];
    assign g_n = rdata[15:8];
    assign b_n = rdata[7:0];
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            px_r_q <= '0;
            px_g_q <= '0;
            px_b_q <= '0;
        end else if (state == FETCH) begin
            px_r_q <= r_n;
            px_g_q <= g_n;
            px_b_q <= b_n;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.px_start = pxs_q;
    assign bus.px_r     = px_r_q;
    assign bus.px_g     = px_g_q;
    assign bus.px_b     = px_b_q;
endmodule

// File: tb/tb_neopixel_strip_ctrl.sv
// Directed bench for neopixel_strip_ctrl with a behavioural writepixel (busy 24 cycles after px_start).
// NUM_PIXELS=6 so that wr_addr values 6 and 7 exercise the out-of-range write filter.
module tb_neopixel_strip_ctrl;
    localparam int NP = 6;
    localparam int LC = 960;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   cyc   = 0;

    neopixel_strip_ctrl_if #(.NUM_PIXELS(NP)) bus ();

    neopixel_strip_ctrl #(.NUM_PIXELS(NP), .CLK_HZ(12000000), .LATCH_US(80)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    int pb_cnt = 0;
    always @(posedge CLK) begin
        if (!RST_N)              pb_cnt <= 0;
        else if (bus.px_start)   pb_cnt <= 24;
        else if (pb_cnt != 0)    pb_cnt <= pb_cnt - 1;
    end
    assign bus.px_busy = (pb_cnt != 0);

    // Monitor: running totals only, so tests work with base snapshots.
    logic [23:0] cap  [1024];
    int          pcyc [1024];
    int np_tot = 0, nd_tot = 0, done_cyc = 0, fall_cyc = 0, bad_busy = 0;
    logic done_busy = 1'b0, pb_prev = 1'b0;
    always @(negedge CLK) begin
        if (bus.px_start) begin
            cap[np_tot % 1024]  = {bus.px_r, bus.px_g, bus.px_b};
            pcyc[np_tot % 1024] = cyc;
            if (!bus.busy) bad_busy++;
            np_tot++;
        end
        if (bus.done) begin
            nd_tot++;
            done_cyc  = cyc;
            done_busy = bus.busy;
        end
        if (pb_prev && !bus.px_busy) fall_cyc = cyc;
        pb_prev = bus.px_busy;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bd);
        int n = 0;
        while (nd_tot == bd && n < 4000) begin tick(); n++; end
        if (nd_tot == bd) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for done", nm);
        end
    endtask

    // One frame from a start pulse; poke>=0 re-pulses start after that many px_start pulses.
    task automatic frame(input string nm, input int poke, output int bp, output int sc);
        int bd, n;
        bit poked;
        bp = np_tot; bd = nd_tot; n = 0; poked = 0;
        bus.start = 1'b1;
        tick();
        sc = cyc;
        bus.start = 1'b0;
        while (nd_tot == bd && n < 4000) begin
            if (poke >= 0 && !poked && (np_tot - bp) == poke) begin
                bus.start = 1'b1; poked = 1;
                tick();
                bus.start = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        if (nd_tot == bd) begin
            checks++; errors++;
            $display("FAIL %s: timeout waiting for done", nm);
        end
        chk({nm, " busy_at_done"}, 32'(done_busy), 32'd0);
        tick(); tick();
        chk({nm, " pulses"}, 32'(np_tot - bp), 32'(NP));
        chk({nm, " dones"},  32'(nd_tot - bd), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [23:0] data;
        int          idx;
        logic [23:0] exp;
    } vec_t;

    vec_t        vt [6];
    logic [23:0] fin [NP];
    logic [23:0] exp_b127, exp_b0;

    initial begin
        int bp, sc, bd, n;
        // Each row: write, run a frame, check one pixel. Rows 0-1 are out of range.
        vt[0] = '{3'd6, 24'hFFFFFF, 5, 24'h050A0F};
        vt[1] = '{3'd7, 24'hFFFFFF, 0, 24'h000000};
        vt[2] = '{3'd0, 24'h123456, 0, 24'h123456};
        vt[3] = '{3'd5, 24'hABCDEF, 5, 24'hABCDEF};
        vt[4] = '{3'd3, 24'h0000FF, 3, 24'h0000FF};
        vt[5] = '{3'd2, 24'hFF00FF, 2, 24'hFF00FF};
        fin = '{24'h123456, 24'h010203, 24'hFF00FF, 24'h0000FF, 24'h04080C, 24'hABCDEF};
`ifdef NEOPIXEL_BRIGHTNESS_EN
        exp_b127 = 24'h7F4000;
        exp_b0   = 24'h000000;
`else
        exp_b127 = 24'hFF8001;
        exp_b0   = 24'hFF8001;
`endif

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.bright = 8'd255; bus.start = 1'b0;
        RST_N = 1'b0;
        tick(); tick();
        chk("rst busy",     32'(bus.busy),     32'd0);
        chk("rst done",     32'(bus.done),     32'd0);
        chk("rst px_start", 32'(bus.px_start), 32'd0);
        chk("rst px_rgb",   32'({bus.px_r, bus.px_g, bus.px_b}), 32'd0);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < NP; i++) wr(3'(i), 24'(32'h010203 * i));

        frame("frame1", -1, bp, sc);
        for (int k = 0; k < NP; k++)
            chk($sformatf("frame1 px%0d", k), 32'(cap[(bp + k) % 1024]), 32'h010203 * k);
        chk("first px_start latency", 32'(pcyc[bp % 1024] - sc), 32'd3);
        // px_busy falls, one WAIT_DONE exit cycle, LC latch cycles, then done.
        chk("latch gap", 32'(done_cyc - fall_cyc), 32'(LC + 1));

        frame("restart_ignored", 3, bp, sc);
        chk("restart px5", 32'(cap[(bp + 5) % 1024]), 32'h050A0F);

        for (int v = 0; v < 6; v++) begin
            wr(vt[v].addr, vt[v].data);
            frame($sformatf("vec%0d", v), -1, bp, sc);
            chk($sformatf("vec%0d px%0d", v, vt[v].idx),
                32'(cap[(bp + vt[v].idx) % 1024]), 32'(vt[v].exp));
        end
        frame("final", -1, bp, sc);
        for (int k = 0; k < NP; k++)
            chk($sformatf("final px%0d", k), 32'(cap[(bp + k) % 1024]), 32'(fin[k]));

        // Reset while pixel 3 (0x0000FF) is in WAIT_DONE.
        bp = np_tot;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n = 0;
        while ((np_tot - bp) < 4 && n < 2000) begin tick(); n++; end
        chk("mid reset reached px3", 32'(np_tot - bp), 32'd4);
        repeat (5) tick();
        RST_N = 1'b0;
        tick();
        chk("mid reset busy",     32'(bus.busy),     32'd0);
        chk("mid reset px_start", 32'(bus.px_start), 32'd0);
        chk("mid reset px_rgb",   32'({bus.px_r, bus.px_g, bus.px_b}), 32'd0);
        RST_N = 1'b1;
        tick();
        frame("after_reset", -1, bp, sc);
        chk("after_reset px0", 32'(cap[bp % 1024]), 32'h123456);

        // start held high: back-to-back frames.
        bp = np_tot; bd = nd_tot;
        bus.start = 1'b1;
        wait_done("held1", bd);
        chk("held busy_at_done", 32'(done_busy), 32'd0);
        tick();
        chk("held busy after done", 32'(bus.busy), 32'd1);
        wait_done("held2", bd + 1);
        bus.start = 1'b0;
        tick();
        chk("held release busy", 32'(bus.busy), 32'd0);
        chk("held pulses", 32'(np_tot - bp), 32'(2 * NP));

        wr(3'd0, 24'hFF8001);
        bus.bright = 8'd127;
        frame("bright127", -1, bp, sc);
        chk("bright127 px0", 32'(cap[bp % 1024]), 32'(exp_b127));
        bus.bright = 8'd255;
        frame("bright255", -1, bp, sc);
        chk("bright255 px0", 32'(cap[bp % 1024]), 32'hFF8001);
        bus.bright = 8'd0;
        frame("bright0", -1, bp, sc);
        chk("bright0 px0", 32'(cap[bp % 1024]), 32'(exp_b0));

        chk("px_start only while busy", 32'(bad_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
